// File: rtl/inst_buffer.sv
// Dual-issue instruction buffer between fetch and decode.
// Accepts up to two instructions per cycle, in order, into a circular array
// and presents the two oldest entries to decode. Backpressure to fetch is a
// pure function of the registered occupancy so no input-to-output path exists.
module inst_buffer #(
    parameter int DEPTH     = 16,
    parameter int PAYLOAD_W = 97,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid0,
    input  logic                 in_valid1,
    input  logic [PAYLOAD_W-1:0] in_payload0,
    input  logic [PAYLOAD_W-1:0] in_payload1,
    output logic                 ifu_full,
    output logic                 out_valid0,
    output logic                 out_valid1,
    output logic [PAYLOAD_W-1:0] out_payload0,
    output logic [PAYLOAD_W-1:0] out_payload1,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PAYLOAD_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic [1:0]       n_enq;
    logic [1:0]       n_deq;
    logic [PTR_W-1:0] head_plus1;
    logic [PTR_W-1:0] tail_slot1;

    // Room for a full pair is guaranteed whenever ifu_full is low.
    assign ifu_full = (cnt > CNT_W'(DEPTH - 2));
    assign accept   = !ifu_full && !flush;

    assign n_enq = accept ? ({1'b0, in_valid0} + {1'b0, in_valid1}) : 2'd0;

    assign out_valid0 = (cnt != '0);
    assign out_valid1 = (cnt >= CNT_W'(2));

    // Decode takes every presented entry at once; flush overrides in the update.
    assign n_deq = out_ready ? ({1'b0, out_valid0} + {1'b0, out_valid1}) : 2'd0;

    // Pointer arithmetic wraps naturally at PTR_W bits (DEPTH is a power of two).
    assign head_plus1 = head + PTR_W'(1);

    // Slot 1 compacts down onto tail when slot 0 is empty.
    assign tail_slot1 = in_valid0 ? (tail + PTR_W'(1)) : tail;

    assign out_payload0 = mem[head];
    assign out_payload1 = mem[head_plus1];
    assign count        = cnt;

    // Storage write: payload is not reset, only written on accepted slots.
    always_ff @(posedge clk) begin
        if (accept && in_valid0) begin
            mem[tail] <= in_payload0;
        end
        if (accept && in_valid1) begin
            mem[tail_slot1] <= in_payload1;
        end
    end

    // Pointer and occupancy update; flush wins over any enqueue or dequeue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + PTR_W'(n_deq);
            tail <= tail + PTR_W'(n_enq);
            cnt  <= cnt + CNT_W'(n_enq) - CNT_W'(n_deq);
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Testbench for inst_buffer: directed vector table, hand-written corner
// sequences and a randomized phase, all checked against a queue-based model.
module tb_inst_buffer;

    localparam int DEPTH     = 16;
    localparam int PAYLOAD_W = 97;
    localparam int CNT_W     = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 flush = 1'b0;
    logic                 in_valid0 = 1'b0;
    logic                 in_valid1 = 1'b0;
    logic [PAYLOAD_W-1:0] in_payload0 = '0;
    logic [PAYLOAD_W-1:0] in_payload1 = '0;
    logic                 ifu_full;
    logic                 out_valid0;
    logic                 out_valid1;
    logic [PAYLOAD_W-1:0] out_payload0;
    logic [PAYLOAD_W-1:0] out_payload1;
    logic                 out_ready = 1'b0;
    logic [CNT_W-1:0]     count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the buffer contents, oldest at index 0.
    logic [PAYLOAD_W-1:0] q[$];

    typedef struct {
        bit          v0;
        bit          v1;
        logic [31:0] pc0;
        logic [31:0] pc1;
        bit          rdy;
        bit          fl;
        int          exp_cnt;
        bit          exp_full;
    } vec_t;

    vec_t tbl[12];

    inst_buffer #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid0   (in_valid0),
        .in_valid1   (in_valid1),
        .in_payload0 (in_payload0),
        .in_payload1 (in_payload1),
        .ifu_full    (ifu_full),
        .out_valid0  (out_valid0),
        .out_valid1  (out_valid1),
        .out_payload0(out_payload0),
        .out_payload1(out_payload1),
        .out_ready   (out_ready),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [PAYLOAD_W-1:0] mk(input logic [31:0] pc);
        return {pc ^ 32'hA5A5_0000, pc, pc[2], pc + 32'h100};
    endfunction

    function automatic logic [31:0] pc_of(input logic [PAYLOAD_W-1:0] p);
        return p[64:33];
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Compare outputs against the model, apply one cycle of inputs, advance both.
    task automatic cycle(input bit v0, input bit v1,
                         input logic [PAYLOAD_W-1:0] p0, input logic [PAYLOAD_W-1:0] p1,
                         input bit rdy, input bit fl);
        int sz;
        int nd;
        bit full_m;
        in_valid0   = v0;
        in_valid1   = v1;
        in_payload0 = p0;
        in_payload1 = p1;
        out_ready   = rdy;
        flush       = fl;
        sz     = q.size();
        full_m = (sz > DEPTH - 2);
        chk("count", 128'(count), 128'(sz));
        chk("ifu_full", 128'(ifu_full), 128'(full_m));
        chk("out_valid0", 128'(out_valid0), 128'(sz >= 1));
        chk("out_valid1", 128'(out_valid1), 128'(sz >= 2));
        if (sz >= 1) chk("out_payload0", 128'(out_payload0), 128'(q[0]));
        if (sz >= 2) chk("out_payload1", 128'(out_payload1), 128'(q[1]));
        if (fl) begin
            q.delete();
        end else begin
            nd = rdy ? ((sz >= 2) ? 2 : sz) : 0;
            repeat (nd) void'(q.pop_front());
            if (!full_m) begin
                if (v0) q.push_back(p0);
                if (v1) q.push_back(p1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 1'b0, '0, '0, rdy, 1'b0);
    endtask

    initial begin
        // Directed vector table: basic pair, drain, fill to full, blocked enqueue, flush.
        tbl[0] = '{v0: 1, v1: 1, pc0: 32'h1000, pc1: 32'h1004, rdy: 0, fl: 0, exp_cnt: 2, exp_full: 0};
        tbl[1] = '{v0: 0, v1: 0, pc0: 32'h0, pc1: 32'h0, rdy: 1, fl: 0, exp_cnt: 0, exp_full: 0};
        for (int k = 0; k < 8; k++) begin
            tbl[2+k] = '{v0: 1, v1: 1, pc0: 32'h3000 + 32'(16 * k), pc1: 32'h3008 + 32'(16 * k),
                         rdy: 0, fl: 0, exp_cnt: 2 * (k + 1), exp_full: (k == 7)};
        end
        tbl[10] = '{v0: 1, v1: 1, pc0: 32'h3100, pc1: 32'h3104, rdy: 0, fl: 0, exp_cnt: 16, exp_full: 1};
        tbl[11] = '{v0: 1, v1: 1, pc0: 32'h3200, pc1: 32'h3204, rdy: 1, fl: 1, exp_cnt: 0, exp_full: 0};

        // Reset held low with random traffic: outputs must stay idle.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid0   = 1'($urandom);
            in_valid1   = 1'($urandom);
            in_payload0 = mk($urandom);
            in_payload1 = mk($urandom);
            out_ready   = 1'b1;
            flush       = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst_count", 128'(count), 128'(0));
            chk("rst_valid", 128'({out_valid0, out_valid1}), 128'(0));
            chk("rst_full", 128'(ifu_full), 128'(0));
        end
        rst = 1'b1;
        q.delete();
        idle(1'b1);
        idle(1'b0);

        // Table-driven phase.
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].v0, tbl[i].v1, mk(tbl[i].pc0), mk(tbl[i].pc1), tbl[i].rdy, tbl[i].fl);
            chk("tbl_count", 128'(count), 128'(tbl[i].exp_cnt));
            chk("tbl_full", 128'(ifu_full), 128'(tbl[i].exp_full));
            if (i == 0) begin
                chk("pair_pc0", 128'(pc_of(out_payload0)), 128'(32'h1000));
                chk("pair_pc1", 128'(pc_of(out_payload1)), 128'(32'h1004));
            end
        end

        // Compaction and wrap: 15 in, 14 out, then slot1-only and a pair.
        for (int k = 0; k < 7; k++) cycle(1, 1, mk(32'h4000 + 32'(8 * k)), mk(32'h4004 + 32'(8 * k)), 0, 0);
        cycle(1, 0, mk(32'h4100), '0, 0, 0);
        for (int k = 0; k < 7; k++) idle(1'b1);
        chk("wrap_count1", 128'(count), 128'(1));
        cycle(0, 1, '0, mk(32'h2000), 0, 0);
        cycle(1, 1, mk(32'h2004), mk(32'h2008), 0, 0);
        chk("wrap_count4", 128'(count), 128'(4));
        chk("wrap_head0", 128'(pc_of(out_payload0)), 128'(32'h4100));
        chk("wrap_head1", 128'(pc_of(out_payload1)), 128'(32'h2000));
        idle(1'b1);
        chk("wrap_next0", 128'(pc_of(out_payload0)), 128'(32'h2004));
        chk("wrap_next1", 128'(pc_of(out_payload1)), 128'(32'h2008));
        idle(1'b1);

        // Simultaneous dequeue of two and enqueue of two with three held.
        cycle(1, 1, mk(32'h6000), mk(32'h6004), 0, 0);
        cycle(1, 0, mk(32'h6008), '0, 0, 0);
        cycle(1, 1, mk(32'h600C), mk(32'h6010), 1, 0);
        chk("simul_count", 128'(count), 128'(3));
        chk("simul_head", 128'(pc_of(out_payload0)), 128'(32'h6008));
        cycle(0, 0, '0, '0, 0, 1);

        // Flush with count 9, concurrent enqueue and ready.
        for (int k = 0; k < 4; k++) cycle(1, 1, mk(32'h7000 + 32'(8 * k)), mk(32'h7004 + 32'(8 * k)), 0, 0);
        cycle(0, 1, '0, mk(32'h7100), 0, 0);
        chk("flush_pre", 128'(count), 128'(9));
        cycle(1, 1, mk(32'h7200), mk(32'h7204), 1, 1);
        chk("flush_count", 128'(count), 128'(0));
        chk("flush_valid", 128'(out_valid0), 128'(0));
        chk("flush_full", 128'(ifu_full), 128'(0));
        cycle(1, 0, mk(32'h5000), '0, 0, 0);
        chk("post_flush_pc", 128'(pc_of(out_payload0)), 128'(32'h5000));
        idle(1'b1);

        // Randomized phase against the model.
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom), 1'($urandom), mk($urandom), mk($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0));
        end
        idle(1'b1);
        idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
Dual-issue instruction buffer at the far end of the fetch-to-decode interface. It receives up to two fetched instructions per cycle, each with PC and prediction metadata, from the fetch unit's output register stage. It presents up to two entries per cycle, oldest first, to decode/rename. It decouples fetch from decode stalls, applies backpressure to fetch, and is cleared on a backend redirect/flush.

Parameters:
DEPTH, 16, number of entries; power of two, >= 4
PAYLOAD_W, 97, opaque per-instruction payload width: {inst[31:0], pc[31:0], pred_taken, pred_target[31:0]}
CNT_W, $clog2(DEPTH)+1, width of the occupancy counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear, driven by the backend redirect or the flush control
in_valid0  in  1  fetch slot 0 valid
in_valid1  in  1  fetch slot 1 valid; slot 1 is younger than slot 0
in_payload0  in  PAYLOAD_W  slot 0 payload
in_payload1  in  PAYLOAD_W  slot 1 payload
ifu_full  out  1  backpressure to fetch; while high, fetch holds its output and the buffer ignores inputs
out_valid0  out  1  head entry valid
out_valid1  out  1  head+1 entry valid
out_payload0  out  PAYLOAD_W  head entry (oldest)
out_payload1  out  PAYLOAD_W  head+1 entry
out_ready  in  1  decode consumes all presented valid entries this cycle
count  out  CNT_W  current occupancy, for debug and performance counters

Behaviour:
- Storage: DEPTH-entry circular array. head/tail pointers are log2(DEPTH) bits, wrap modulo DEPTH. Occupancy register cnt is in the range 0..DEPTH.
- Reset (rst=0, asynchronous): head=0, tail=0, cnt=0. Outputs: ifu_full=0, out_valid0=0, out_valid1=0, count=0. out_payload* are don't-care. Storage contents are not reset.
- ifu_full = (cnt > DEPTH-2). It is a function of registered cnt only; there is no combinational path from in_* or out_ready.
- Enqueue rule, when ifu_full=0 and flush=0:
  - n_enq = in_valid0 + in_valid1.
  - Valid slots are compacted in order: slot 0 goes to tail, then slot 1 to the next free position.
  - If only in_valid1=1, slot 1 is written to tail.
  - tail advances by n_enq.
- When ifu_full=1, inputs are ignored (n_enq=0). Fetch guarantees the data is held.
- Output rule:
  - out_valid0 = (cnt>=1); out_valid1 = (cnt>=2).
  - out_payload0 = mem[head]; out_payload1 = mem[head+1 mod DEPTH].
  - Outputs are combinational reads of registered state. Enqueued data is visible at the earliest one cycle after the write (no bypass).
- Dequeue rule: n_deq = out_ready ? (out_valid0 + out_valid1) : 0. head advances by n_deq.
- Same-cycle enqueue and dequeue: cnt_next = cnt + n_enq - n_deq. This is always in range, given the full rule.
- Dequeue reads pre-update state, so an entry written this cycle is never dequeued in the same cycle.
- Flush has highest priority: next cycle head=0, tail=0, cnt=0. Any same-cycle enqueue and dequeue are discarded, and out_ready has no effect.
- Wrap-around: pointer arithmetic is modulo DEPTH. Slot 1 may be written at index 0 when tail=DEPTH-1. out_payload1 reads index 0 when head=DEPTH-1.
- Ordering invariant: entries leave in exactly the order they were accepted. Within a cycle, slot 0 is older than slot 1.
- Latency: one cycle from acceptance to out_valid when empty; throughput is 2 entries per cycle sustained.

Test Plan:
- Reset: hold rst=0 with random inputs and out_ready=1 -> out_valid0/1=0, ifu_full=0, count=0 throughout. After release, entries appear only after a valid enqueue.
- Basic pair: in_valid0/1=1 with pc 0x1000/0x1004, out_ready=0 -> next cycle count=2, out_valid0/1=1, out_payload pcs 0x1000/0x1004. Then out_ready=1 for one cycle -> count=0.
- Fill: DEPTH=16, out_ready=0, enqueue 2 per cycle -> count=14 after 7 cycles with ifu_full=0. After the 8th cycle count=16, ifu_full=1. A further enqueue attempt leaves count=16.
- Compaction and wrap: enqueue 15 entries, dequeue 14, then drive slot1-only (pc 0x2000) followed by a pair (0x2004/0x2008) -> dequeued order is oldest remaining, then 0x2000, 0x2004, 0x2008, with indices wrapping past 15 -> 0.
- Simultaneous: with count=3, out_ready=1 and a 2-wide enqueue in the same cycle -> count=3 (2+2 removed/added with 1 left + 2). out_payload0 is the former third entry.
- Flush: count=9 with a concurrent enqueue and out_ready=1, flush=1 -> next cycle count=0, out_valid0=0, ifu_full=0. The next enqueue lands at index 0.
